// File: rtl/jedro_1_mem_pkg.sv
// Shared types and constants for the jedro_1 data-memory responder and its byte-write RAM.
package jedro_1_mem_pkg;

    localparam int BE_WIDTH   = 4;
    localparam int BYTE_WIDTH = 8;
    localparam int WORD_WIDTH = BE_WIDTH * BYTE_WIDTH;

    localparam int LANE_0 = 0;
    localparam int LANE_1 = 1;
    localparam int LANE_2 = 2;
    localparam int LANE_3 = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // The wait counter is loaded with LATENCY-2, so it must hold values up to that.
    function automatic int lat_cnt_width(input int latency);
        return (latency > 2) ? $clog2(latency - 1) : 1;
    endfunction

endpackage

// File: rtl/jedro_1_bytewrite_ram.sv
// Word RAM with per-byte write enables and a registered read port.
module jedro_1_bytewrite_ram
    import jedro_1_mem_pkg::*;
#(
    parameter int    DEPTH         = 256,
    parameter int    IDX_WIDTH     = $clog2(DEPTH),
    parameter string MEM_INIT_FILE = ""
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [BE_WIDTH-1:0]   be_i,
    input  logic [IDX_WIDTH-1:0]  waddr_i,
    input  logic [WORD_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [IDX_WIDTH-1:0]  raddr_i,
    output logic [WORD_WIDTH-1:0] rdata_o
);

    logic [WORD_WIDTH-1:0] mem_q [DEPTH];
    logic [WORD_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int k = 0; k < BE_WIDTH; k++) begin
                if (be_i[k]) begin
                    mem_q[waddr_i][k*BYTE_WIDTH +: BYTE_WIDTH] <= wdata_i[k*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // Read port only updates on a load, so its output stays stable through WAIT.
    always_ff @(posedge clk_i) begin
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/jedro_1_data_ram_responder.sv
// Data-memory responder for the jedro_1 load/store port with a programmable response latency.
// Optional misaligned-access error reporting is enabled by defining JEDRO_1_DATA_RAM_MISALIGN_ERR_EN.
module jedro_1_data_ram_responder
    import jedro_1_mem_pkg::*;
#(
    parameter int    DATA_WIDTH    = 32,
    parameter int    ADDR_WIDTH    = 32,
    parameter int    DEPTH         = 256,
    parameter int    LATENCY       = 2,
    parameter string MEM_INIT_FILE = ""
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_i,
    output logic                  ready_o,
    input  logic                  we_i,
    input  logic [BE_WIDTH-1:0]   be_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  rvalid_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  err_o
);

    localparam int IDX_WIDTH = $clog2(DEPTH);
    localparam int CNT_WIDTH = lat_cnt_width(LATENCY);
    localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'((LATENCY > 1) ? LATENCY - 2 : 0);

    state_e                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic                  accept;
    logic                  misalign;
    logic [IDX_WIDTH-1:0]  idx;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  ram_we;
    logic                  ram_re;
    logic                  unused_addr;

    assign idx         = addr_i[2 +: IDX_WIDTH];
    assign unused_addr = ^addr_i;

`ifdef JEDRO_1_DATA_RAM_MISALIGN_ERR_EN
    assign misalign = |addr_i[1:0];
`else
    assign misalign = 1'b0;
`endif

    assign ready_o = ~rst_i & ((state_q == ST_IDLE) | (state_q == ST_RESP));
    assign accept  = req_i & ready_o;
    assign ram_we  = accept & we_i & ~misalign;
    assign ram_re  = accept & ~we_i;

    jedro_1_bytewrite_ram #(
        .DEPTH         (DEPTH),
        .IDX_WIDTH     (IDX_WIDTH),
        .MEM_INIT_FILE (MEM_INIT_FILE)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (ram_we),
        .be_i    (be_i),
        .waddr_i (idx),
        .wdata_i (wdata_i),
        .re_i    (ram_re),
        .raddr_i (idx),
        .rdata_o (ram_rdata)
    );

    // Stores leave the held data alone; a flagged load returns zero.
    always_comb begin
        resp_rdata = rdata_q;
        if (!we_q) begin
            resp_rdata = err_q ? '0 : ram_rdata;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        err_d   = err_q;
        rdata_d = rdata_q;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                rdata_d = resp_rdata;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A new request can only arrive in IDLE or RESP, so it overrides the transition above.
        if (accept) begin
            we_d    = we_i;
            err_d   = misalign;
            cnt_d   = CNT_LOAD;
            state_d = (LATENCY == 1) ? ST_RESP : ST_WAIT;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign rvalid_o = (state_q == ST_RESP);
    assign rdata_o  = rvalid_o ? resp_rdata : rdata_q;
    assign err_o    = rvalid_o & err_q;

endmodule

// File: tb/tb_jedro_1_data_ram_responder.sv
// Bench for jedro_1_data_ram_responder: three instances at LATENCY 2, 1 and 4 on a shared clock.
module tb_jedro_1_data_ram_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [2:0]        req, we;
    logic [2:0][3:0]   be;
    logic [2:0][31:0]  addr, wdata;
    wire  [2:0]        ready, rvalid, err;
    wire  [2:0][31:0]  rdata;

    int checks   = 0;
    int failures = 0;
    int lat_of [3] = '{2, 1, 4};

    jedro_1_data_ram_responder #(.LATENCY(2)) u_lat2 (
        .clk_i(clk), .rst_i(rst), .req_i(req[0]), .ready_o(ready[0]), .we_i(we[0]), .be_i(be[0]),
        .addr_i(addr[0]), .wdata_i(wdata[0]), .rvalid_o(rvalid[0]), .rdata_o(rdata[0]), .err_o(err[0]));

    jedro_1_data_ram_responder #(.LATENCY(1)) u_lat1 (
        .clk_i(clk), .rst_i(rst), .req_i(req[1]), .ready_o(ready[1]), .we_i(we[1]), .be_i(be[1]),
        .addr_i(addr[1]), .wdata_i(wdata[1]), .rvalid_o(rvalid[1]), .rdata_o(rdata[1]), .err_o(err[1]));

    jedro_1_data_ram_responder #(.LATENCY(4)) u_lat4 (
        .clk_i(clk), .rst_i(rst), .req_i(req[2]), .ready_o(ready[2]), .we_i(we[2]), .be_i(be[2]),
        .addr_i(addr[2]), .wdata_i(wdata[2]), .rvalid_o(rvalid[2]), .rdata_o(rdata[2]), .err_o(err[2]));

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one request on instance d and follow it to its response.
    task automatic do_req(input int d, input logic w, input logic [3:0] b, input logic [31:0] a,
                          input logic [31:0] wd, output int lat, output logic [31:0] rd,
                          output logic e, output logic bad_rdy, output logic bad_pulse);
        int guard;
        guard     = 0;
        bad_rdy   = 1'b0;
        bad_pulse = 1'b0;
        req[d]    = 1'b1;
        we[d]     = w;
        be[d]     = b;
        addr[d]   = a;
        wdata[d]  = wd;
        while (!ready[d] && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        @(negedge clk);
        req[d]  = 1'b0;
        we[d]   = 1'b0;
        addr[d] = '1;
        lat     = 1;
        while (!rvalid[d] && lat < 20) begin
            if (ready[d]) bad_rdy = 1'b1;
            @(negedge clk);
            lat++;
        end
        rd = rdata[d];
        e  = err[d];
        if (!ready[d]) bad_rdy = 1'b1;
        @(negedge clk);
        bad_pulse = rvalid[d];
    endtask

    task automatic chk_resp(input string tag, input int d, input int lat, input logic [31:0] rd,
                            input logic e, input logic bad_rdy, input logic bad_pulse,
                            input logic [31:0] exp_rd, input logic exp_e);
        chk({tag, "_lat"}, lat, lat_of[d]);
        chk({tag, "_rdata"}, rd, exp_rd);
        chk({tag, "_err"}, {31'd0, e}, {31'd0, exp_e});
        chk({tag, "_ready"}, {31'd0, bad_rdy}, 32'd0);
        chk({tag, "_pulse"}, {31'd0, bad_pulse}, 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs [12];
        int          lat;
        logic [31:0] rd;
        logic        e, bad_rdy, bad_pulse, seen;
        logic [31:0] feat_load_exp;
        logic        feat_err_exp;

        vecs[0]  = '{1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000};
        vecs[1]  = '{1'b0, 4'hF, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 4'hF, 32'h0000_0020, 32'h0000_0000, 32'hDEAD_BEEF};
        vecs[3]  = '{1'b1, 4'h5, 32'h0000_0020, 32'h1122_3344, 32'hDEAD_BEEF};
        vecs[4]  = '{1'b0, 4'h0, 32'h0000_0020, 32'h0,         32'h0022_0044};
        vecs[5]  = '{1'b1, 4'hF, 32'h0000_0080, 32'hCAFE_F00D, 32'h0022_0044};
        vecs[6]  = '{1'b1, 4'h1, 32'h0000_0080, 32'h0000_00AB, 32'h0022_0044};
        vecs[7]  = '{1'b1, 4'h0, 32'h0000_0080, 32'hFFFF_FFFF, 32'h0022_0044};
        vecs[8]  = '{1'b0, 4'hF, 32'h0000_0080, 32'h0,         32'hCAFE_F0AB};
        vecs[9]  = '{1'b1, 4'hF, 32'h0000_0030, 32'h0000_000F, 32'hCAFE_F0AB};
        vecs[10] = '{1'b0, 4'hF, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF};
        vecs[11] = '{1'b0, 4'hF, 32'h0000_1010, 32'h0,         32'hDEAD_BEEF};

`ifdef JEDRO_1_DATA_RAM_MISALIGN_ERR_EN
        feat_err_exp  = 1'b1;
        feat_load_exp = 32'h1357_9BDF;
`else
        feat_err_exp  = 1'b0;
        feat_load_exp = 32'hFFFF_FFFF;
`endif

        rst   = 1'b1;
        req   = '0;
        we    = '0;
        be    = '0;
        addr  = '0;
        wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst%0d_ready", d), {31'd0, ready[d]}, 32'd0);
            chk($sformatf("rst%0d_rvalid", d), {31'd0, rvalid[d]}, 32'd0);
            chk($sformatf("rst%0d_rdata", d), rdata[d], 32'd0);
            chk($sformatf("rst%0d_err", d), {31'd0, err[d]}, 32'd0);
        end
        rst = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("idle%0d_ready", d), {31'd0, ready[d]}, 32'd1);
        end

        for (int i = 0; i < 12; i++) begin
            do_req(0, vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wdata, lat, rd, e, bad_rdy, bad_pulse);
            chk_resp($sformatf("v%0d", i), 0, lat, rd, e, bad_rdy, bad_pulse, vecs[i].exp_rdata, 1'b0);
        end

        // Store to 0x400 (wraps to word 0), then a load of 0x000 accepted on the RESP edge.
        req[0] = 1'b1; we[0] = 1'b1; be[0] = 4'hF; addr[0] = 32'h0000_0400; wdata[0] = 32'hA5A5_A5A5;
        @(posedge clk);
        @(negedge clk);
        chk("b2b_wait_ready", {31'd0, ready[0]}, 32'd0);
        chk("b2b_wait_rvalid", {31'd0, rvalid[0]}, 32'd0);
        we[0] = 1'b0; addr[0] = 32'h0000_0000;
        @(posedge clk);
        @(negedge clk);
        chk("b2b_st_rvalid", {31'd0, rvalid[0]}, 32'd1);
        chk("b2b_st_ready", {31'd0, ready[0]}, 32'd1);
        chk("b2b_st_rdata", rdata[0], 32'hDEAD_BEEF);
        @(posedge clk);
        @(negedge clk);
        req[0] = 1'b0;
        chk("b2b_ld_wait_rvalid", {31'd0, rvalid[0]}, 32'd0);
        chk("b2b_ld_wait_ready", {31'd0, ready[0]}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("b2b_ld_rvalid", {31'd0, rvalid[0]}, 32'd1);
        chk("b2b_ld_rdata", rdata[0], 32'hA5A5_A5A5);
        @(negedge clk);
        chk("b2b_ld_pulse", {31'd0, rvalid[0]}, 32'd0);
        chk("b2b_ld_hold", rdata[0], 32'hA5A5_A5A5);

        // Reset while a load of 0x30 is waiting: its response must never appear.
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h0000_0030;
        @(posedge clk);
        @(negedge clk);
        req[0] = 1'b0;
        rst    = 1'b1;
        #1;
        chk("mid_rst_ready", {31'd0, ready[0]}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (rvalid[0]) seen = 1'b1;
            @(negedge clk);
        end
        chk("mid_rst_no_rvalid", {31'd0, seen}, 32'd0);
        chk("mid_rst_rdata", rdata[0], 32'd0);
        do_req(0, 1'b0, 4'hF, 32'h0000_0030, 32'h0, lat, rd, e, bad_rdy, bad_pulse);
        chk_resp("post_rst", 0, lat, rd, e, bad_rdy, bad_pulse, 32'h0000_000F, 1'b0);

        // Misaligned store to 0x41 followed by an aligned load of 0x40.
        do_req(0, 1'b1, 4'hF, 32'h0000_0040, 32'h1357_9BDF, lat, rd, e, bad_rdy, bad_pulse);
        chk_resp("mis_pre", 0, lat, rd, e, bad_rdy, bad_pulse, 32'h0000_000F, 1'b0);
        do_req(0, 1'b1, 4'hF, 32'h0000_0041, 32'hFFFF_FFFF, lat, rd, e, bad_rdy, bad_pulse);
        chk_resp("mis_st", 0, lat, rd, e, bad_rdy, bad_pulse, 32'h0000_000F, feat_err_exp);
        do_req(0, 1'b0, 4'hF, 32'h0000_0040, 32'h0, lat, rd, e, bad_rdy, bad_pulse);
        chk_resp("mis_ld", 0, lat, rd, e, bad_rdy, bad_pulse, feat_load_exp, 1'b0);
`ifdef JEDRO_1_DATA_RAM_MISALIGN_ERR_EN
        do_req(0, 1'b0, 4'hF, 32'h0000_0042, 32'h0, lat, rd, e, bad_rdy, bad_pulse);
        chk_resp("mis_ld_err", 0, lat, rd, e, bad_rdy, bad_pulse, 32'h0, 1'b1);
`endif

        // Latency 1 and 4 instances: store then load, measuring accept-to-response.
        for (int d = 1; d < 3; d++) begin
            do_req(d, 1'b1, 4'hF, 32'h0000_0008, 32'h0102_0304, lat, rd, e, bad_rdy, bad_pulse);
            chk_resp($sformatf("l%0d_st", lat_of[d]), d, lat, rd, e, bad_rdy, bad_pulse, 32'h0, 1'b0);
            do_req(d, 1'b0, 4'hF, 32'h0000_0008, 32'h0, lat, rd, e, bad_rdy, bad_pulse);
            chk_resp($sformatf("l%0d_ld", lat_of[d]), d, lat, rd, e, bad_rdy, bad_pulse, 32'h0102_0304, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
